// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
// Holds operand width, iteration count, op encodings and FSM states.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_MUL3  = 2'b11   // behaves as OP_MUL
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // Magnitude of a 32-bit two's-complement value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [MUL_WIDTH-1:0] abs_w(input logic [MUL_WIDTH-1:0] x);
    return x[MUL_WIDTH-1] ? MUL_WIDTH'(~x + MUL_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier, one shift-add step per cycle (32 steps).
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   Start     - begin a multiply (sampled only in IDLE)
//   MulOp     - 00 MUL, 01 UMULL, 10 SMULL, 11 MUL
//   SrcA/SrcB - multiplicand / multiplier, captured with Start
//   Busy      - high while in RUN or DONE
//   Done      - one-cycle pulse when results become valid
//   ResultLo/ResultHi - product words (ResultHi = 0 for MUL)
//   MulFlags  - {N,Z} of the result
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  localparam int unsigned PW = 2 * WIDTH;

  mul_state_e           state_q, state_d;
  mul_op_e              op_q, op_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 sign_q, sign_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [1:0]           flags_q, flags_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PW-1:0]        addend;
  logic [PW-1:0]        acc_next;
  logic [PW-1:0]        final_prod;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, shift-add step and result formatting
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    flags_d  = flags_q;

    // Add the multiplicand weighted by the current multiplier bit position.
    addend     = mplier_q[cnt_q] ? (PW'(mcand_q) << cnt_q) : '0;
    acc_next   = acc_q + addend;
    final_prod = sign_q ? PW'(~acc_next + PW'(1)) : acc_next;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          op_d    = mul_op_e'(MulOp);
          acc_d   = '0;
          cnt_d   = '0;
          if (mul_op_e'(MulOp) == OP_SMULL) begin
            mcand_d  = abs_w(SrcA);
            mplier_d = abs_w(SrcB);
            sign_d   = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
          end else begin
            mcand_d  = SrcA;
            mplier_d = SrcB;
            sign_d   = 1'b0;
          end
        end
      end

      ST_RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == MUL_CNT_W'(MUL_ITERS - 1)) begin
          state_d = ST_DONE;
          if (op_q == OP_UMULL || op_q == OP_SMULL) begin
            lo_d    = final_prod[WIDTH-1:0];
            hi_d    = final_prod[PW-1:WIDTH];
            flags_d = {final_prod[PW-1], final_prod == '0};
          end else begin
            lo_d    = final_prod[WIDTH-1:0];
            hi_d    = '0;
            flags_d = {final_prod[WIDTH-1], final_prod[WIDTH-1:0] == '0};
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: scoreboard of expected products.
module tb_mul_seq;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MulOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] ResultLo, ResultHi;
  logic [1:0]  MulFlags;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MulOp    (MulOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .MulFlags (MulFlags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product computed with native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b01:   p = {32'h0, a} * {32'h0, b};
      2'b10:   p = sa * sb;
      default: p = {32'h0, 32'(a * b)};
    endcase
    e.lo = p[31:0];
    if (op == 2'b01 || op == 2'b10) begin
      e.hi    = p[63:32];
      e.flags = {p[63], p == 64'h0};
    end else begin
      e.hi    = 32'h0;
      e.flags = {p[31], p[31:0] == 32'h0};
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    check_eq({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      last_exp = sb_q.pop_front();
      check_eq({tag, "_lo"},    64'(ResultLo), 64'(last_exp.lo));
      check_eq({tag, "_hi"},    64'(ResultHi), 64'(last_exp.hi));
      check_eq({tag, "_flags"}, 64'(MulFlags), 64'(last_exp.flags));
    end
  endtask

  // One operation; optionally pulses Start with new operands at cycle 'glitch'.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int glitch);
    int k;
    int nd;
    Start = 1'b1; MulOp = op; SrcA = a; SrcB = b;
    sb_q.push_back(model(op, a, b));
    step();
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MulOp = 2'($urandom);
    check_eq({tag, "_busy"}, 64'(Busy), 64'd1);
    k = 1;
    while (!Done && k < 40) begin
      Start = (k == glitch);
      if (k == glitch) begin
        SrcA = $urandom; SrcB = $urandom;
      end
      step();
      k++;
    end
    Start = 1'b0;
    check_eq({tag, "_done"}, 64'(Done), 64'd1);
    check_eq({tag, "_latency"}, 64'(k), 64'd33);
    check_result(tag);
    step();
    check_eq({tag, "_done_pulse"}, 64'(Done), 64'd0);
    check_eq({tag, "_idle"}, 64'(Busy), 64'd0);
    check_eq({tag, "_hold_lo"}, 64'(ResultLo), 64'(last_exp.lo));
    check_eq({tag, "_hold_hi"}, 64'(ResultHi), 64'(last_exp.hi));
    if (glitch > 0) begin
      nd = 0;
      repeat (40) begin
        step();
        if (Done) nd++;
      end
      check_eq({tag, "_no_extra_done"}, 64'(nd), 64'd0);
    end
  endtask

  initial begin
    int nd;
    int k;
    reset = 1'b1; Start = 1'b0; MulOp = 2'b00; SrcA = '0; SrcB = '0;
    step(); step();
    check_eq("rst_busy",  64'(Busy),     64'd0);
    check_eq("rst_done",  64'(Done),     64'd0);
    check_eq("rst_lo",    64'(ResultLo), 64'd0);
    check_eq("rst_hi",    64'(ResultHi), 64'd0);
    check_eq("rst_flags", 64'(MulFlags), 64'd0);
    reset = 1'b0;
    step();

    run_op("mul_7x6",     2'b00, 32'd7,          32'd6,          0);
    run_op("umull_max",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
    run_op("smull_m3x5",  2'b10, 32'hFFFF_FFFD,  32'd5,          0);
    run_op("smull_minsq", 2'b10, 32'h8000_0000,  32'h8000_0000,  0);
    run_op("mul_zero",    2'b00, 32'h0001_0000,  32'h0001_0000,  0);
    run_op("umull_2_32",  2'b01, 32'h0001_0000,  32'h0001_0000,  0);
    run_op("mul3_op",     2'b11, 32'h1234_5678,  32'h9ABC_DEF0,  0);
    run_op("smull_pxn",   2'b10, 32'd123456,     32'hFFFF_0000,  0);
    run_op("smull_zero",  2'b10, 32'h8000_0000,  32'd0,          0);
    run_op("glitch",      2'b01, 32'hDEAD_BEEF,  32'h0000_1001,  10);

    // Abort mid-RUN with reset (Start also high: reset wins).
    Start = 1'b1; MulOp = 2'b01; SrcA = 32'hCAFE_F00D; SrcB = 32'h1357_9BDF;
    step();
    Start = 1'b0;
    repeat (14) step();
    reset = 1'b1; Start = 1'b1;
    step();
    check_eq("abort_busy",  64'(Busy),     64'd0);
    check_eq("abort_done",  64'(Done),     64'd0);
    check_eq("abort_lo",    64'(ResultLo), 64'd0);
    check_eq("abort_hi",    64'(ResultHi), 64'd0);
    check_eq("abort_flags", 64'(MulFlags), 64'd0);
    reset = 1'b0; Start = 1'b0;
    nd = 0;
    repeat (40) begin
      step();
      if (Done) nd++;
    end
    check_eq("abort_no_done", 64'(nd), 64'd0);
    run_op("after_abort", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 0);

    // Start held high: back-to-back operations every 34 cycles.
    Start = 1'b1; MulOp = 2'b10; SrcA = 32'hFFFF_FFF9; SrcB = 32'd9;
    sb_q.push_back(model(2'b10, 32'hFFFF_FFF9, 32'd9));
    sb_q.push_back(model(2'b10, 32'hFFFF_FFF9, 32'd9));
    nd = 0;
    k  = 0;
    while (k < 75) begin
      step();
      k++;
      if (k == 35) begin
        Start = 1'b0;
        check_eq("b2b_restart_busy", 64'(Busy), 64'd1);
      end
      if (Done) begin
        check_eq("b2b_done_cycle", 64'(k), (nd == 0) ? 64'd33 : 64'd67);
        check_result("b2b");
        nd++;
      end
    end
    check_eq("b2b_done_count", 64'(nd), 64'd2);

    // Random operations.
    for (int i = 0; i < 6; i++) begin
      run_op("rand", 2'($urandom), $urandom, $urandom, 0);
    end

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port MulOp  input  2  operation: 00 MUL (32-bit low result), 01 UMULL, 10 SMULL, 11 treated as MUL.
REQ-006 The block SHALL have port SrcA  input  32  multiplicand, captured with Start.
REQ-007 The block SHALL have port SrcB  input  32  multiplier, captured with Start.
REQ-008 The block SHALL have port Busy  output  1  high in RUN and DONE states.
REQ-009 The block SHALL have port Done  output  1  one-cycle pulse; results and flags valid from this cycle.
REQ-010 The block SHALL have port ResultLo  output  32  low product word.
REQ-011 The block SHALL have port ResultHi  output  32  high product word; 0 for MUL.
REQ-012 The block SHALL have port MulFlags  output  2  {N,Z} of the result.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN when Start=1; RUN->DONE after exactly 32 iterations; DONE->IDLE unconditionally.
REQ-014 On IDLE->RUN: latch MulOp; for SMULL latch |SrcA|, |SrcB| and sign = SrcA[31]^SrcB[31]; otherwise latch raw operands; clear 64-bit accumulator and 5-bit iteration counter.
REQ-015 Each RUN cycle: one shift-add step (add multiplicand shifted by counter, or shift-right accumulator form) using multiplier bit; counter increments; 32 steps total.
REQ-016 Latency: Start high in cycle 0 -> cycles 1..32 RUN -> Done high in cycle 33 only.
REQ-017 On RUN->DONE: SMULL with sign=1 yields two's-complement negation of the 64-bit magnitude; ResultLo/ResultHi/MulFlags registered at this edge.
REQ-018 |0x80000000| SHALL be handled as unsigned 0x80000000 (33rd bit not required; magnitude fits 32 unsigned bits).
REQ-019 MUL/11: ResultHi=0, N=ResultLo[31], Z=(ResultLo==0); UMULL/SMULL: N=ResultHi[31], Z=(64-bit result==0).
REQ-020 ResultLo, ResultHi, MulFlags SHALL hold their values after Done until the next RUN->DONE edge.
REQ-021 Start while Busy=1 SHALL be ignored with no queuing; SrcA/SrcB/MulOp changes during RUN SHALL not affect the result.
REQ-022 Start held high continuously SHALL start a new operation in each IDLE cycle (back-to-back period 34 cycles).

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, Busy=0, Done=0, ResultLo=0, ResultHi=0, MulFlags=0, counter=0, from any state including mid-RUN.
REQ-024 reset SHALL take priority over Start in the same cycle; the aborted operation SHALL produce no Done.

Structure
REQ-025 A shared package mul_pkg SHALL hold MulOp encodings, FSM state encoding, WIDTH and iteration-count constant.
REQ-026 The design SHALL be one module with no sub-modules; the 64-bit negation is inline logic.

Verification
REQ-027 MUL: SrcA=7, SrcB=6, Start in cycle 0 -> Done in cycle 33, ResultLo=42, ResultHi=0, MulFlags=00.
REQ-028 UMULL: 0xFFFFFFFF x 0xFFFFFFFF -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
REQ-029 SMULL: -3 x 5 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1, N=1; 0x80000000 x 0x80000000 -> 0x40000000_00000000, N=0.
REQ-030 MUL 0x10000 x 0x10000 -> ResultLo=0, Z=1; same via UMULL -> ResultHi=1, Z=0.
REQ-031 Start pulsed in cycle 10 during RUN with new operands -> ignored, first result unchanged, no extra Done.
REQ-032 reset in cycle 15 of RUN -> cycle 16 Busy=0, outputs 0, no Done; new Start afterward completes in 33 cycles.
